// File: rtl/rad_mon_pkg.sv
// Shared types and helpers for the radiation shift-chain monitor:
// monitor state encoding, the 16-bit Fibonacci LFSR taps and step function.
package rad_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2
    } mon_state_e;

    // Taps for x^16+x^14+x^13+x^11+1 expressed as state bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One Fibonacci step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is mapped to 1.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/shift_chain_monitor_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load and advance enable.
// Output bit of the stream is state[15].
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    input  logic        advance,
    input  logic        load_seed,
    output logic [15:0] state
);
    import rad_mon_pkg::*;

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Next state: reload wins over advance, otherwise hold.
    always_comb begin
        state_d = state_q;
        if (load_seed) begin
            state_d = seed;
        end else if (advance) begin
            state_d = lfsr_next(state_q);
        end
    end

    // State register, reset to the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/shift_chain_monitor.sv
// Stimulus/check wrapper for one monitored shift chain. lfsr_a drives a
// pseudo-random stream into the chain; lfsr_b regenerates the same stream
// LAT cycles later so chain_q can be compared bit by bit without storing it.
module shift_chain_monitor #(
    parameter int          SHIFT_LENGTH = 16,
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter int          COUNT_WIDTH  = 16,
    parameter int          CHECK_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   inject,
    output logic                   chain_d,
    input  logic                   chain_q,
    output logic                   running,
    output logic                   err_pulse,
    output logic                   err_flag,
    output logic [COUNT_WIDTH-1:0] err_count,
    output logic [CHECK_WIDTH-1:0] bits_checked
);
    import rad_mon_pkg::*;

    // Chain latency: SHIFT_LENGTH+1 flops between chain_d and chain_q.
    localparam int                 LAT       = SHIFT_LENGTH + 1;
    localparam int                 FILL_W    = $clog2(LAT + 1);
    localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(LAT - 1);
    localparam logic [15:0]        SEED_EFF  = seed_fix(SEED);

    mon_state_e              state_q, state_d;
    logic [FILL_W-1:0]       fill_cnt_q, fill_cnt_d;
    logic                    running_q, running_d;
    logic                    err_pulse_q, err_pulse_d;
    logic                    err_flag_q, err_flag_d;
    logic [COUNT_WIDTH-1:0]  err_count_q, err_count_d;
    logic [CHECK_WIDTH-1:0]  bits_checked_q, bits_checked_d;

    logic [15:0] lfsr_a;
    logic [15:0] lfsr_b;
    logic        a_load, a_adv;
    logic        b_load, b_adv;
    logic        in_check;
    logic        mismatch;
    logic        lfsr_unused;

    // Only the stream bit of each LFSR is consumed here.
    assign lfsr_unused = ^{lfsr_a[14:0], lfsr_b[14:0]};

    // Sequencing: IDLE -> FILL for exactly LAT cycles -> CHECK; enable low aborts to IDLE.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (fill_cnt_q == FILL_LAST) begin
                    state_d = CHECK;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
            CHECK: begin
                if (!enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        running_d = (state_d == CHECK);
    end

    // LFSR control: the generator runs in FILL/CHECK, the model only in CHECK;
    // both go back to the seed whenever the run is idle or being dropped.
    always_comb begin
        a_load = (state_q == IDLE) || !enable;
        a_adv  = !a_load;
        b_load = (state_q != CHECK) || !enable;
        b_adv  = !b_load;
    end

    lfsr16 u_lfsr_a (
        .clk       (clk),
        .rst       (rst),
        .seed      (SEED_EFF),
        .advance   (a_adv),
        .load_seed (a_load),
        .state     (lfsr_a)
    );

    lfsr16 u_lfsr_b (
        .clk       (clk),
        .rst       (rst),
        .seed      (SEED_EFF),
        .advance   (b_adv),
        .load_seed (b_load),
        .state     (lfsr_b)
    );

    // Stream into the chain; inject flips only the current bit so alignment is kept.
    assign chain_d = (state_q != IDLE) & (lfsr_a[15] ^ inject);

    // Compare and count: clear wins over a same-cycle mismatch, counters saturate.
    always_comb begin
        in_check       = (state_q == CHECK);
        mismatch       = in_check & (chain_q ^ lfsr_b[15]);
        err_pulse_d    = 1'b0;
        err_flag_d     = err_flag_q;
        err_count_d    = err_count_q;
        bits_checked_d = bits_checked_q;
        if (clear) begin
            err_flag_d     = 1'b0;
            err_count_d    = '0;
            bits_checked_d = '0;
        end else begin
            if (mismatch) begin
                err_pulse_d = 1'b1;
                err_flag_d  = 1'b1;
                if (~&err_count_q) begin
                    err_count_d = err_count_q + 1'b1;
                end
            end
            if (in_check && (~&bits_checked_q)) begin
                bits_checked_d = bits_checked_q + 1'b1;
            end
        end
    end

    // State, fill counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            fill_cnt_q     <= '0;
            running_q      <= 1'b0;
            err_pulse_q    <= 1'b0;
            err_flag_q     <= 1'b0;
            err_count_q    <= '0;
            bits_checked_q <= '0;
        end else begin
            state_q        <= state_d;
            fill_cnt_q     <= fill_cnt_d;
            running_q      <= running_d;
            err_pulse_q    <= err_pulse_d;
            err_flag_q     <= err_flag_d;
            err_count_q    <= err_count_d;
            bits_checked_q <= bits_checked_d;
        end
    end

    assign running      = running_q;
    assign err_pulse    = err_pulse_q;
    assign err_flag     = err_flag_q;
    assign err_count    = err_count_q;
    assign bits_checked = bits_checked_q;

endmodule

// File: tb/tb_shift_chain_monitor.sv
// Bench for shift_chain_monitor: two instances (16-bit and 4-bit error
// counters) each closed around a behavioural 17-flop chain. Expected error
// pulse cycles are queued when an upset is driven and matched every cycle.
module tb_shift_chain_monitor;

  localparam int          LAT     = 17;
  localparam logic [15:0] TB_SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic inject = 1'b0;
  logic force_main = 1'b0;
  logic force_sat = 1'b0;

  logic        chain_d, chain_q, running, err_pulse, err_flag;
  logic [15:0] err_count;
  logic [31:0] bits_checked;

  logic        sat_chain_d, sat_chain_q, sat_running, sat_err_pulse, sat_err_flag;
  logic [3:0]  sat_err_count;
  logic [31:0] sat_bits_checked;

  logic [LAT-1:0] sr_main = '0;
  logic [LAT-1:0] sr_sat = '0;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;
  logic [31:0] exp_q[$];

  // clock / cycle counter / behavioural chains
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    sr_main <= {sr_main[LAT-2:0], chain_d};
    sr_sat <= {sr_sat[LAT-2:0], sat_chain_d};
  end

  assign chain_q = sr_main[LAT-1] ^ force_main;
  assign sat_chain_q = sr_sat[LAT-1] ^ force_sat;

  shift_chain_monitor #(
    .SHIFT_LENGTH(16), .SEED(TB_SEED), .COUNT_WIDTH(16), .CHECK_WIDTH(32)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .inject(inject),
    .chain_d(chain_d), .chain_q(chain_q), .running(running),
    .err_pulse(err_pulse), .err_flag(err_flag), .err_count(err_count),
    .bits_checked(bits_checked)
  );

  shift_chain_monitor #(
    .SHIFT_LENGTH(16), .SEED(TB_SEED), .COUNT_WIDTH(4), .CHECK_WIDTH(32)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .inject(inject),
    .chain_d(sat_chain_d), .chain_q(sat_chain_q), .running(sat_running),
    .err_pulse(sat_err_pulse), .err_flag(sat_err_flag), .err_count(sat_err_count),
    .bits_checked(sat_bits_checked)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called in FILL cycle 0: measures fill latency and checks the driven stream.
  task automatic do_fill(input string tag);
    int n;
    logic [LAT-1:0] got;
    logic [LAT-1:0] exp_bits;
    logic [15:0] s;
    got = '0;
    n = 0;
    while (!running && n < 40) begin
      got = {got[LAT-2:0], chain_d};
      step();
      n++;
    end
    check({tag, "_latency"}, n, LAT);
    s = TB_SEED;
    exp_bits = '0;
    for (int i = 0; i < LAT; i++) begin
      exp_bits = {exp_bits[LAT-2:0], s[15]};
      s = model_next(s);
    end
    check({tag, "_stream"}, got, exp_bits);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_chain_d"}, chain_d, 0);
    check({tag, "_running"}, running, 0);
    check({tag, "_err_pulse"}, err_pulse, 0);
    check({tag, "_err_flag"}, err_flag, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_bits_checked"}, bits_checked, 0);
  endtask

  // scoreboard: every cycle, err_pulse must be high exactly on queued cycles
  always @(negedge clk) begin
    logic exp_p;
    if (mon_en) begin
      exp_p = 1'b0;
      if (exp_q.size() > 0 && exp_q[0] == cyc) begin
        exp_p = 1'b1;
        void'(exp_q.pop_front());
      end
      check("err_pulse_sb", err_pulse, exp_p);
    end
  end

  initial begin
    // reset
    step_n(2);
    rst = 1'b0;
    check_reset_outputs("reset");
    mon_en = 1'b1;

    // 1: fill latency, stream, clean run
    enable = 1'b1;
    step();
    do_fill("fill1");
    step_n(1000);
    check("run_err_count", err_count, 0);
    check("run_bits_checked", bits_checked, 1000);
    check("run_err_flag", err_flag, 0);

    // 2: single injected upset
    inject = 1'b1;
    exp_q.push_back(cyc + 18);
    step();
    inject = 1'b0;
    step_n(30);
    check("inject_err_count", err_count, 1);
    check("inject_err_flag", err_flag, 1);

    // 3: five forced mismatches after a clear
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_err_count", err_count, 0);
    check("clear_err_flag", err_flag, 0);
    check("clear_bits_checked", bits_checked, 0);
    for (int i = 0; i < 5; i++) begin
      force_main = 1'b1;
      exp_q.push_back(cyc + 1);
      step();
    end
    force_main = 1'b0;
    step_n(3);
    check("force5_err_count", err_count, 5);
    check("force5_bits_checked", bits_checked, 8);

    // 4: 4-bit counter saturation on the second instance
    force_sat = 1'b1;
    step_n(20);
    check("sat_err_count", sat_err_count, 15);
    check("sat_err_pulse_on", sat_err_pulse, 1);
    check("sat_err_flag", sat_err_flag, 1);
    check("sat_running", sat_running, 1);
    check("sat_bits_checked", sat_bits_checked, 28);
    force_sat = 1'b0;
    step_n(3);
    check("sat_err_count_hold", sat_err_count, 15);
    check("sat_err_pulse_off", sat_err_pulse, 0);
    check("main_err_count_kept", err_count, 5);

    // 5: clear in the same cycle as a mismatch
    force_main = 1'b1;
    clear = 1'b1;
    step();
    force_main = 1'b0;
    clear = 1'b0;
    check("clr_mm_err_count", err_count, 0);
    check("clr_mm_err_flag", err_flag, 0);
    check("clr_mm_err_pulse", err_pulse, 0);
    inject = 1'b1;
    exp_q.push_back(cyc + 18);
    step();
    inject = 1'b0;
    step_n(25);
    check("post_clr_err_count", err_count, 1);
    check("post_clr_err_flag", err_flag, 1);

    // 6a: drop enable mid-CHECK, then restart
    enable = 1'b0;
    step();
    check("drop_running", running, 0);
    check("drop_chain_d", chain_d, 0);
    check("drop_err_count", err_count, 1);
    check("drop_err_flag", err_flag, 1);
    inject = 1'b1;
    #1;
    check("idle_inject_chain_d", chain_d, 0);
    inject = 1'b0;
    step();
    check("idle_inject_err_count", err_count, 1);
    enable = 1'b1;
    step();
    do_fill("refill");
    step_n(100);
    check("refill_err_count", err_count, 1);

    // 6b: reset in the middle of FILL
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    step_n(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midfill_rst");
    step();
    do_fill("post_rst");
    step_n(50);
    check("post_rst_err_count", err_count, 0);
    check("post_rst_bits_checked", bits_checked, 50);
    check("post_rst_err_flag", err_flag, 0);

    step_n(2);
    check("pending_pulses", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
